// File: rtl/mdu_ctrl_if.sv
// Handshake/data bundle between the E stage and the multiply/divide controller.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface mdu_ctrl_if;
  logic        MDU_Start;
  logic [3:0]  MDU_Op;
  logic [31:0] MDU_A;
  logic [31:0] MDU_B;
  logic        MDU_Busy;
  logic [31:0] MDU_HI;
  logic [31:0] MDU_LO;
  logic [31:0] MDU_Out;

  modport master (
    output MDU_Start, MDU_Op, MDU_A, MDU_B,
    input  MDU_Busy, MDU_HI, MDU_LO, MDU_Out
  );

  modport slave (
    input  MDU_Start, MDU_Op, MDU_A, MDU_B,
    output MDU_Busy, MDU_HI, MDU_LO, MDU_Out
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO. The result is computed at launch into
// pending registers and committed to HI/LO when the busy countdown expires.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mdu_ctrl_if.slave    bus
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic [31:0] res_hi, res_lo;
  logic        launch;

  always_comb begin
    prod_s = $unsigned($signed({{32{bus.MDU_A[31]}}, bus.MDU_A}) *
                       $signed({{32{bus.MDU_B[31]}}, bus.MDU_B}));
    prod_u = {32'd0, bus.MDU_A} * {32'd0, bus.MDU_B};
    quo_u  = '1;
    rem_u  = bus.MDU_A;
    quo_s  = '1;
    rem_s  = bus.MDU_A;
    if (bus.MDU_B != '0) begin
      quo_u = bus.MDU_A / bus.MDU_B;
      rem_u = bus.MDU_A % bus.MDU_B;
      // Most-negative / -1 overflows; pin the wrapped quotient explicitly.
      if (bus.MDU_A == 32'h8000_0000 && bus.MDU_B == 32'hFFFF_FFFF) begin
        quo_s = 32'h8000_0000;
        rem_s = '0;
      end else begin
        quo_s = $unsigned($signed(bus.MDU_A) / $signed(bus.MDU_B));
        rem_s = $unsigned($signed(bus.MDU_A) % $signed(bus.MDU_B));
      end
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (bus.MDU_Op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = rem_s;         res_lo = quo_s;        end
      OP_DIVU:  begin res_hi = rem_u;         res_lo = quo_u;        end
      default:  ;
    endcase
  end

  assign launch = bus.MDU_Start && (bus.MDU_Op >= OP_MULT) && (bus.MDU_Op <= OP_DIVU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d   = ST_BUSY;
          cnt_d     = (bus.MDU_Op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
        end else if (bus.MDU_Op == OP_MTHI) begin
          hi_d = bus.MDU_A;
        end else if (bus.MDU_Op == OP_MTLO) begin
          lo_d = bus.MDU_A;
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign bus.MDU_Busy = (state_q == ST_BUSY);
  assign bus.MDU_HI   = hi_q;
  assign bus.MDU_LO   = lo_q;
  assign bus.MDU_Out  = (bus.MDU_Op == OP_MFHI) ? hi_q :
                        (bus.MDU_Op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table, hand-written corner sequences and random
// traffic, all checked every cycle against a 64-bit arithmetic reference model.
module tb_mdu_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_rem;
  logic        last_busy;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return 64'(ua * ub);
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic void model_reset();
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_rem = 0;
  endfunction

  function automatic void model_edge(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (st && op >= 4'd1 && op <= 4'd4) begin
      r     = ref_calc(op, a, b);
      m_phi = r[63:32];
      m_plo = r[31:0];
      m_rem = (op <= 4'd2) ? 5 : 10;
    end else if (op == 4'd5) begin
      m_hi = a;
    end else if (op == 4'd6) begin
      m_lo = a;
    end
  endfunction

  // Entered and left at posedge+1; drives one cycle, checks at negedge, steps model at posedge.
  task automatic cycle(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_out;
    bus.MDU_Start = st;
    bus.MDU_Op    = op;
    bus.MDU_A     = a;
    bus.MDU_B     = b;
    @(negedge clk);
    exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    last_busy = bus.MDU_Busy;
    check("busy", {31'd0, bus.MDU_Busy}, {31'd0, m_rem > 0});
    check("hi",   bus.MDU_HI,  m_hi);
    check("lo",   bus.MDU_LO,  m_lo);
    check("out",  bus.MDU_Out, exp_out);
    @(posedge clk);
    model_edge(st, op, a, b);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.MDU_Start = 1'b0;
    bus.MDU_Op    = 4'd0;
    bus.MDU_A     = '0;
    bus.MDU_B     = '0;
    model_reset();

    #3;
    check("reset_busy", {31'd0, bus.MDU_Busy}, 32'd0);
    check("reset_hi",   bus.MDU_HI, 32'd0);
    check("reset_lo",   bus.MDU_LO, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back('{"mult_neg",   4'd1, 32'hFFFF_FFFD, 32'd5,        5,  32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{"div_neg",    4'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_7_2",   4'd4, 32'd7,         32'd2,        10, 32'd1,         32'd3});
    vecs.push_back('{"divu_by0",   4'd4, 32'd1234,      32'd0,        10, 32'h0000_04D2, 32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf",    4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,        32'h8000_0000});
    vecs.push_back('{"div_by0",    4'd3, 32'hFFFF_FFF0, 32'd0,        10, 32'hFFFF_FFF0, 32'hFFFF_FFFF});
    vecs.push_back('{"multu_big",  4'd2, 32'h0001_0000, 32'h0001_0000, 5, 32'd1,         32'd0});
    vecs.push_back('{"div_7_neg2", 4'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,        32'hFFFF_FFFD});

    foreach (vecs[i]) begin
      int n;
      int guard;
      cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      n = 0;
      guard = 0;
      do begin
        idle();
        if (last_busy) n++;
        guard++;
      end while (last_busy && guard < 40);
      check({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].cycles));
      check({vecs[i].name, "_hi"}, bus.MDU_HI, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, bus.MDU_LO, vecs[i].exp_lo);
    end

    // Start DIV and MTHI during a MULTU are dropped
    cycle(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle();
    cycle(1'b1, 4'd3, 32'd100, 32'd7);
    cycle(1'b0, 4'd5, 32'hDEAD_BEEF, 32'd0);
    cycle(1'b0, 4'd7, 32'd0, 32'd0);
    idle();
    check("ign_busy", {31'd0, bus.MDU_Busy}, 32'd0);
    check("ign_hi",   bus.MDU_HI, 32'hFFFF_FFFE);
    check("ign_lo",   bus.MDU_LO, 32'h0000_0001);

    // MTHI then MFHI
    cycle(1'b0, 4'd5, 32'hCAFE_BABE, 32'd0);
    bus.MDU_Op = 4'd7;
    #1;
    check("mfhi_out",  bus.MDU_Out, 32'hCAFE_BABE);
    check("mfhi_busy", {31'd0, bus.MDU_Busy}, 32'd0);
    cycle(1'b0, 4'd7, 32'd0, 32'd0);
    cycle(1'b0, 4'd6, 32'h1234_5678, 32'd0);

    // Reset in busy cycle 4 of a DIV
    cycle(1'b1, 4'd3, 32'd1000, 32'd3);
    idle(); idle(); idle();
    bus.MDU_Start = 1'b0;
    bus.MDU_Op    = 4'd0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_busy", {31'd0, bus.MDU_Busy}, 32'd0);
    check("rst_hi",   bus.MDU_HI, 32'd0);
    check("rst_lo",   bus.MDU_LO, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) idle();
    check("rst_nohi", bus.MDU_HI, 32'd0);
    check("rst_nolo", bus.MDU_LO, 32'd0);
    cycle(1'b1, 4'd1, 32'd6, 32'd7);
    for (int i = 0; i < 6; i++) idle();
    check("post_rst_lo", bus.MDU_LO, 32'd42);
    check("post_rst_hi", bus.MDU_HI, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 8)), rnd32(), rnd32());
    end
    for (int i = 0; i < 12; i++) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
